// File: rtl/data_cache_m.sv
// data_cache_m: direct-mapped, write-through, no-write-allocate data cache.
// Multi-word lines are refilled one word per memAck beat; the core is held
// off with a stall derived from the state register while memory is busy.
// Optional statistics outputs (hitCount/missCount) are enabled by defining
// DCACHE_STATS_EN.
module data_cache_m #(
    parameter int NUM_LINES      = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] aluResult,
    input  logic [31:0] writeDataMem,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] readData,
    output logic        readValid,
    output logic        stall,
    output logic        addrError,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [31:0] memWriteData,
    input  logic        memAck,
    input  logic [31:0] memReadData
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0] hitCount,
    output logic [31:0] missCount
`endif
);

    localparam int INDEX_BITS  = $clog2(NUM_LINES);
    localparam int OFFSET_BITS = $clog2(WORDS_PER_LINE);
    localparam int TAG_BITS    = 30 - INDEX_BITS - OFFSET_BITS;
    localparam int OFFSET_W    = (OFFSET_BITS > 0) ? OFFSET_BITS : 1;
    localparam int LINE_BYTES  = WORDS_PER_LINE * 4;

    typedef enum logic [1:0] {IDLE, REFILL, RESPOND, WRITE} cacheState_t;

    cacheState_t state, nextState;

    // Line storage: tag and data arrays plus per-line valid bits.
    logic [TAG_BITS-1:0] tagArray  [NUM_LINES];
    logic [31:0]         dataArray [NUM_LINES][WORDS_PER_LINE];
    logic [NUM_LINES-1:0] validBits;

    // Miss context captured when a refill starts.
    logic [TAG_BITS-1:0]   reqTag;
    logic [INDEX_BITS-1:0] reqIndex;
    logic [OFFSET_W-1:0]   reqOffset;
    logic [OFFSET_W-1:0]   beat;

    // Address decode of the incoming request.
    logic [29:0]           wordAddr;
    logic [TAG_BITS-1:0]   reqTagIn;
    logic [INDEX_BITS-1:0] reqIndexIn;
    logic [OFFSET_W-1:0]   reqOffsetIn;

    assign wordAddr    = aluResult[31:2];
    assign reqTagIn    = TAG_BITS'(wordAddr >> (INDEX_BITS + OFFSET_BITS));
    assign reqIndexIn  = INDEX_BITS'(wordAddr >> OFFSET_BITS);
    assign reqOffsetIn = OFFSET_W'(wordAddr & 30'(WORDS_PER_LINE - 1));

    logic hit, idleReq, misaligned, acceptRead, acceptWrite, ackBeat, lastBeat;

    assign hit         = validBits[reqIndexIn] && (tagArray[reqIndexIn] == reqTagIn);
    assign idleReq     = (state == IDLE) && (MemRead || MemWrite);
    assign misaligned  = (aluResult[1:0] != 2'b00);
    assign acceptWrite = idleReq && !misaligned && MemWrite;
    assign acceptRead  = idleReq && !misaligned && !MemWrite;
    assign ackBeat     = (state == REFILL) && memAck;
    assign lastBeat    = (beat == OFFSET_W'(WORDS_PER_LINE - 1));

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    // Next-state decode.
    always_comb begin
        // NOTE: defaulting before the case keeps this block free of latches.
        nextState = state;
        unique case (state)
            IDLE: begin
                if (acceptWrite)             nextState = WRITE;
                else if (acceptRead && !hit) nextState = REFILL;
            end
            REFILL:  if (memAck && lastBeat) nextState = RESPOND;
            RESPOND: nextState = IDLE;
            WRITE:   if (memAck) nextState = IDLE;
        endcase
    end

    // Handshake outputs decoded straight from the state flops.
    always_comb begin
        stall  = (state != IDLE);
        memReq = (state == REFILL) || (state == WRITE);
        memWe  = (state == WRITE);
    end

    // Registered response, error pulse and memory address/data path.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readData     <= '0;
            readValid    <= 1'b0;
            addrError    <= 1'b0;
            memAddr      <= '0;
            memWriteData <= '0;
            reqTag       <= '0;
            reqIndex     <= '0;
            reqOffset    <= '0;
            beat         <= '0;
        end else begin
            readValid <= 1'b0;
            addrError <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (idleReq && misaligned) begin
                        addrError <= 1'b1;
                    end else if (acceptWrite) begin
                        memAddr      <= aluResult;
                        memWriteData <= writeDataMem;
                    end else if (acceptRead) begin
                        if (hit) begin
                            readData  <= dataArray[reqIndexIn][reqOffsetIn];
                            readValid <= 1'b1;
                        end else begin
                            reqTag    <= reqTagIn;
                            reqIndex  <= reqIndexIn;
                            reqOffset <= reqOffsetIn;
                            beat      <= '0;
                            memAddr   <= aluResult & ~32'(LINE_BYTES - 1);
                        end
                    end
                end
                REFILL: begin
                    if (memAck) begin
                        beat    <= beat + 1'b1;
                        memAddr <= memAddr + 32'd4;
                    end
                end
                RESPOND: begin
                    readData  <= dataArray[reqIndex][reqOffset];
                    readValid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Valid bits: cleared when a refill starts, set after its final beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            validBits <= '0;
        end else if (acceptRead && !hit) begin
            validBits[reqIndexIn] <= 1'b0;
        end else if (ackBeat && lastBeat) begin
            validBits[reqIndex] <= 1'b1;
        end
    end

    // Tag/data array writes from refill beats and write hits.
    always_ff @(posedge clk) begin
        // NOTE: the arrays carry no reset; the valid bits alone decide
        // whether their contents are meaningful.
        if (ackBeat) dataArray[reqIndex][beat] <= memReadData;
        if (ackBeat && lastBeat) tagArray[reqIndex] <= reqTag;
        if (acceptWrite && hit) dataArray[reqIndexIn][reqOffsetIn] <= writeDataMem;
    end

`ifdef DCACHE_STATS_EN
    // Hit/miss counters for accepted, aligned requests.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hitCount  <= '0;
            missCount <= '0;
        end else if (acceptRead || acceptWrite) begin
            if (hit) hitCount  <= hitCount + 32'd1;
            else     missCount <= missCount + 32'd1;
        end
    end
`endif

endmodule
